// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, single-outstanding imem reader, 2-entry instruction FIFO with redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets set oMISALIGN and halt fetching.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [31:0] iPCBR,
   input  logic        iPCBR_VALID,
   output logic        oIMEM_REQ,
   output logic [31:0] oIMEM_ADDR,
   input  logic        iIMEM_GNT,
   input  logic        iIMEM_RVALID,
   input  logic [31:0] iIMEM_RDATA,
   output logic [31:0] oIR,
   output logic [31:0] oPC,
   output logic        oIR_VALID,
   input  logic        iIR_READY,
   output logic        oMISALIGN
);
`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
`endif
   state_t      state_q;
   logic [31:0] pc_q, req_addr_q, ir0_q, pc0_q, ir1_q, pc1_q;
   logic [31:0] ir0_d, pc0_d, ir1_d, pc1_d, target;
   logic [1:0]  count_q, count_d;
   logic        drop_q, bad, fire, pop, push, wr1, pend;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_q;
   assign target    = iPCBR;
   assign bad       = iPCBR[1:0] != 2'b00;
   assign oMISALIGN = misalign_q;
`else
   logic        unused_lsb;
   assign unused_lsb = ^iPCBR[1:0];
   assign target     = {iPCBR[31:2], 2'b00};
   assign bad        = 1'b0;
   assign oMISALIGN  = 1'b0;
`endif
   assign oIMEM_REQ  = (state_q == S_REQ) && !count_q[1];
   assign oIMEM_ADDR = pc_q;
   assign oIR        = ir0_q;
   assign oPC        = pc0_q;
   assign oIR_VALID  = count_q != 2'd0;
   assign fire = oIMEM_REQ & iIMEM_GNT;
   assign pop  = oIR_VALID & iIR_READY;
   assign push = (state_q == S_WAIT) & iIMEM_RVALID & ~drop_q;
   // a response is still owed to us after this cycle, so a redirect must squash it
   assign pend = fire | ((state_q == S_WAIT) & ~iIMEM_RVALID);
   assign wr1  = count_q[1] | (count_q[0] & ~pop);
   always_comb begin
      ir0_d   = (push & ~wr1) ? iIMEM_RDATA : pop ? ir1_q : ir0_q;
      pc0_d   = (push & ~wr1) ? req_addr_q : pop ? pc1_q : pc0_q;
      ir1_d   = (push & wr1) ? iIMEM_RDATA : ir1_q;
      pc1_d   = (push & wr1) ? req_addr_q : pc1_q;
      count_d = iPCBR_VALID ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
   end
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= 32'd0;
         ir0_q      <= 32'd0;
         pc0_q      <= 32'd0;
         ir1_q      <= 32'd0;
         pc1_q      <= 32'd0;
         count_q    <= 2'd0;
         drop_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         ir0_q   <= ir0_d;
         pc0_q   <= pc0_d;
         ir1_q   <= ir1_d;
         pc1_q   <= pc1_d;
         count_q <= count_d;
         case (state_q)
            S_IDLE: state_q <= S_REQ;
            S_REQ: if (fire) begin
               req_addr_q <= pc_q;
               pc_q       <= pc_q + 32'd4;
               state_q    <= S_WAIT;
            end
            S_WAIT: if (iIMEM_RVALID) begin
               drop_q  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
               state_q <= misalign_q ? S_HALT : S_REQ;
`else
               state_q <= S_REQ;
`endif
            end
            default: ;
         endcase
         if (iPCBR_VALID) begin
            if (!bad) pc_q <= target;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q <= bad;
`endif
            if (pend) begin
               drop_q  <= 1'b1;
               state_q <= S_WAIT;
            end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
               state_q <= bad ? S_HALT : S_REQ;
`else
               state_q <= S_REQ;
`endif
            end
         end
      end
   end
endmodule
